// File: rtl/lut_neuron_prog_pkg.sv
// Shared types and default geometry for the programmable LUT neuron.
// Derived constants describe the default table; the top recomputes them from its own parameters.
package lut_neuron_prog_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int DEF_IN_BITS   = 8;
  localparam int DEF_OUT_BITS  = 2;
  localparam int DEF_PACK      = 4;
  localparam int DEF_CFG_W     = DEF_OUT_BITS * DEF_PACK;
  localparam int DEF_NUM_WORDS = (1 << DEF_IN_BITS) / DEF_PACK;

  // Width of a counter over n words; never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lut_neuron_ram.sv
// Distributed-RAM lookup table: PACK entries written per cycle, asynchronous read.
// No reset on storage; contents are only meaningful after a completed load.
import lut_neuron_prog_pkg::*;

module lut_neuron_ram #(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int PACK     = DEF_PACK,
  parameter int WADDR_W  = cnt_w(DEF_NUM_WORDS)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [WADDR_W-1:0]       waddr,
  input  logic [OUT_BITS*PACK-1:0] wdata,
  input  logic [IN_BITS-1:0]       raddr,
  output logic [OUT_BITS-1:0]      rdata
);
  localparam int DEPTH = 1 << IN_BITS;

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int j = 0; j < PACK; j++)
        mem[IN_BITS'(int'(waddr) * PACK + j)] <= wdata[OUT_BITS*j +: OUT_BITS];
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/lut_neuron_prog.sv
// Programmable LUT neuron: streamed table load, then 1-cycle lookups through a
// one-deep output register with ready/valid on both sides.
import lut_neuron_prog_pkg::*;

module lut_neuron_prog #(
  parameter int IN_BITS  = DEF_IN_BITS,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int PACK     = DEF_PACK
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic [OUT_BITS*PACK-1:0] cfg_data,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  output logic                     cfg_done,
  input  logic [IN_BITS-1:0]       in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [OUT_BITS-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam int CFG_W     = OUT_BITS * PACK;
  localparam int NUM_WORDS = (1 << IN_BITS) / PACK;
  localparam int WCNT_W    = cnt_w(NUM_WORDS);
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

  state_t              state;
  logic [WCNT_W-1:0]   wcnt;
  logic                run;
  logic                we;
  logic                in_acc;
  logic [OUT_BITS-1:0] rd_data;

  // A word arriving alongside cfg_start belongs to the aborted load and is dropped.
  assign we       = cfg_ready && cfg_valid && !cfg_start;
  assign in_ready = run && (!out_valid || out_ready);
  assign in_acc   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      wcnt      <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      run       <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        ST_EMPTY, ST_RUN: begin
          if (cfg_start) begin
            state     <= ST_LOAD;
            wcnt      <= '0;
            cfg_ready <= 1'b1;
            run       <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (cfg_start) begin
            wcnt <= '0;
          end else if (cfg_valid) begin
            if (wcnt == LAST_WORD) begin
              state     <= ST_RUN;
              wcnt      <= '0;
              cfg_ready <= 1'b0;
              cfg_done  <= 1'b1;
              run       <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_EMPTY;
          wcnt      <= '0;
          cfg_ready <= 1'b0;
          run       <= 1'b0;
        end
      endcase
    end
  end

  // Output register is independent of the FSM so a pending result survives a reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_acc) begin
      out_valid <= 1'b1;
      out_data  <= rd_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  lut_neuron_ram #(
    .IN_BITS (IN_BITS),
    .OUT_BITS(OUT_BITS),
    .PACK    (PACK),
    .WADDR_W (WCNT_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wcnt),
    .wdata(cfg_data[CFG_W-1:0]),
    .raddr(in_data),
    .rdata(rd_data)
  );
endmodule
